// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side signals of the TX byte-stream arbiter.
// The master modport is the arbiter; the slave modport is its surroundings.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_full;
    logic [N-1:0]   grant;
    logic           busy;

    modport master (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_valid, tx_data, grant, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_valid, tx_data, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX byte stream among N requesters.
// Optional macro UART_ARB_HDR_EN inserts a header byte {4'hA, owner} before each grant's payload.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int MAX_LEN = 64
) (
    input  logic                 sys_clk,
    input  logic                 sys_nrst,
    uart_tx_arbiter_if.master    bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HDR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               tx_valid_c;
    logic [7:0]         tx_data_c;
    logic [N-1:0]       req_ready_c;
    logic [IDX_W-1:0]   pick;

    // First valid requester after the pointer, wrapping; the last owner is searched last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] v,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               k;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(p) + i) % N;
            if (!found && v[k]) begin
                sel   = IDX_W'(k);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.req_valid, ptr_q);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        tx_valid_c  = 1'b0;
        tx_data_c   = 8'h00;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    gidx_d       = pick;
                    grant_d      = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d        = '0;
`ifdef UART_ARB_HDR_EN
                    state_d      = HDR;
`else
                    state_d      = SEND;
`endif
                end
            end

`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (!bus.tx_full) begin
                    tx_valid_c = 1'b1;
                    tx_data_c  = {4'hA, 4'(gidx_q)};
                    state_d    = SEND;
                end
            end
`endif

            SEND: begin
                if (bus.req_valid[gidx_q] && !bus.tx_full) begin
                    tx_valid_c  = 1'b1;
                    tx_data_c   = bus.req_data[{gidx_q, 3'b000} +: 8];
                    req_ready_c = grant_q;
                    cnt_d       = cnt_q + CNT_W'(1);
                    // Release on end of packet or when the grant has used its byte budget.
                    if (bus.req_last[gidx_q] || cnt_q == CNT_W'(MAX_LEN - 1)) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.tx_valid  = tx_valid_c;
    assign bus.tx_data   = tx_data_c;
    assign bus.req_ready = req_ready_c;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level reference model predicts every
// cycle's status and every TX byte; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int MAX_LEN = 4;
`ifdef UART_ARB_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic sys_clk  = 1'b0;
    logic sys_nrst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(.N(N), .MAX_LEN(MAX_LEN)) dut (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .bus      (bus)
    );

    typedef struct { logic [7:0] d; bit last; } beat_t;
    typedef struct { logic [7:0] d; logic [N-1:0] ready; } xfer_t;
    typedef struct { bit txv; logic [N-1:0] grant; bit busy; } stat_t;

    beat_t rq[N][$];     // pending bytes per requester
    xfer_t xq[$];        // expected TX bytes
    stat_t sq[$];        // expected per-cycle status

    int errors = 0;
    int checks = 0;

    // Reference model: owner of the stream (-1 = nobody), RR pointer, bytes in this grant.
    int owner    = -1;
    int ptr      = N - 1;
    int cnt      = 0;
    bit hdr_pend = 1'b0;
    int sent     = 0;

    int vprob = 100;
    int fprob = 0;
    bit drop[N];
    bit full_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input bit last);
        beat_t b;
        b.d = d;
        b.last = last;
        rq[r].push_back(b);
    endtask

    task automatic load(input int r, input int len, input logic [7:0] base, input bit with_last);
        for (int k = 0; k < len; k++)
            push_beat(r, base + 8'(k), with_last && (k == len - 1));
    endtask

    function automatic bit model_idle();
        bit e = (owner < 0);
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Drive one cycle of inputs and predict what the arbiter shows during that cycle.
    task automatic step(input bit do_rst);
        logic [N-1:0] v;
        bit           full;
        stat_t        s;
        xfer_t        x;
        beat_t        b;
        int           c;
        for (int i = 0; i < N; i++) begin
            v[i] = (rq[i].size() > 0) && !drop[i] && ($urandom_range(1, 100) <= vprob);
            bus.req_valid[i]       = v[i];
            bus.req_data[8*i +: 8] = v[i] ? rq[i][0].d : 8'($urandom);
            bus.req_last[i]        = v[i] ? rq[i][0].last : 1'($urandom);
        end
        full = full_force || ($urandom_range(1, 100) <= fprob);
        bus.tx_full = full;

        if (do_rst) begin
            sys_nrst = 1'b0;
            #1;
            check("rst_tx_valid", bus.tx_valid, 0);
            check("rst_tx_data", bus.tx_data, 0);
            check("rst_grant", bus.grant, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_req_ready", bus.req_ready, 0);
            owner = -1; ptr = N - 1; cnt = 0; hdr_pend = 1'b0;
            for (int i = 0; i < N; i++) rq[i].delete();
            s.txv = 1'b0; s.grant = '0; s.busy = 1'b0;
            sq.push_back(s);
            return;
        end

        s.txv   = 1'b0;
        s.grant = '0;
        if (owner >= 0) s.grant[owner] = 1'b1;
        s.busy  = (owner >= 0);

        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (owner < 0 && v[c]) owner = c;
            end
            cnt = 0;
            hdr_pend = HDR_EN;
        end else if (hdr_pend) begin
            if (!full) begin
                s.txv = 1'b1;
                x.d = 8'hA0 | 8'(owner);
                x.ready = '0;
                xq.push_back(x);
                hdr_pend = 1'b0;
            end
        end else if (v[owner] && !full) begin
            b = rq[owner].pop_front();
            s.txv = 1'b1;
            x.d = b.d;
            x.ready = '0;
            x.ready[owner] = 1'b1;
            xq.push_back(x);
            cnt++;
            sent++;
            if (b.last || cnt == MAX_LEN) begin
                ptr = owner;
                owner = -1;
            end
        end
        sq.push_back(s);
    endtask

    task automatic cycle(input bit do_rst);
        @(posedge sys_clk);
        #1;
        if (!sys_nrst && !do_rst) sys_nrst = 1'b1;
        step(do_rst);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            cycle(1'b0);
            n++;
        end
        repeat (2) cycle(1'b0);
    endtask

    // Monitor: status every cycle, byte contents whenever the arbiter strobes tx_valid.
    initial begin
        stat_t s;
        xfer_t x;
        forever begin
            @(negedge sys_clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                check("tx_valid", bus.tx_valid, s.txv);
                check("grant", bus.grant, s.grant);
                check("busy", bus.busy, s.busy);
                if (bus.tx_valid) begin
                    if (xq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h with no byte expected", bus.tx_data);
                    end else begin
                        x = xq.pop_front();
                        check("tx_data", bus.tx_data, x.d);
                        check("req_ready", bus.req_ready, x.ready);
                    end
                end else begin
                    if (s.txv && xq.size() > 0) void'(xq.pop_front());
                    check("idle_tx_data", bus.tx_data, 0);
                    check("idle_req_ready", bus.req_ready, 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int fc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;
        for (int i = 0; i < N; i++) drop[i] = 1'b0;

        repeat (2) @(negedge sys_clk);
        check("reset_tx_valid", bus.tx_valid, 0);
        check("reset_tx_data", bus.tx_data, 0);
        check("reset_grant", bus.grant, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_req_ready", bus.req_ready, 0);

        // Single requester, three-byte packet.
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h22, 1'b0);
        push_beat(1, 8'h33, 1'b1);
        run(50);

        // From reset, all four requesters with two-byte packets; requester 0 comes back.
        cycle(1'b1);
        for (int r = 0; r < N; r++) load(r, 2, 8'(8'h40 + 16 * r), 1'b1);
        load(0, 2, 8'h48, 1'b1);
        run(100);

        // tx_full held for five cycles after the first byte.
        push_beat(0, 8'hA1, 1'b0);
        push_beat(0, 8'hA2, 1'b0);
        push_beat(0, 8'hA3, 1'b1);
        s0 = sent; fc = 0;
        while (!model_idle() && fc < 100) begin
            full_force = (sent - s0 == 1) && (fc < 5);
            if (full_force) fc++;
            cycle(1'b0);
        end
        full_force = 1'b0;
        run(20);

        // Forced release at MAX_LEN with a competing requester.
        load(2, 10, 8'h20, 1'b1);
        cycle(1'b0);
        load(3, 8, 8'h30, 1'b1);
        run(200);

        // Owner drops valid mid-packet while another requester waits.
        load(1, 5, 8'h60, 1'b1);
        cycle(1'b0);
        load(0, 2, 8'h70, 1'b1);
        s0 = sent; fc = 0;
        while (!model_idle() && fc < 100) begin
            drop[1] = (sent - s0 == 2) && (fc < 3);
            if (drop[1]) fc++;
            cycle(1'b0);
        end
        drop[1] = 1'b0;
        run(20);

        // Reset during the second byte of a four-byte packet.
        load(1, 4, 8'h80, 1'b1);
        s0 = sent; fc = 0;
        while (sent - s0 < 1 && fc < 20) begin
            cycle(1'b0);
            fc++;
        end
        cycle(1'b1);
        load(0, 3, 8'h50, 1'b1);
        load(1, 4, 8'h80, 1'b1);
        run(100);

        // Randomized traffic with random valid gaps and back-pressure.
        vprob = 70;
        fprob = 25;
        repeat (10) begin
            repeat ($urandom_range(1, 5)) begin
                int r   = $urandom_range(0, N - 1);
                int len = $urandom_range(1, 7);
                for (int k = 0; k < len; k++)
                    push_beat(r, 8'($urandom), k == len - 1);
            end
            run(2000);
        end
        vprob = 100;
        fprob = 0;

        repeat (3) cycle(1'b0);
        check("scoreboard_drained", xq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
